alu_div32: RTL

Iterative 32-bit integer divider, the inverse of the array multiplier in the ALU family. It accepts a dividend and divisor with a start pulse and runs a restoring shift-subtract loop, one quotient bit per clock. It returns quotient, remainder and ALU-style status flags with a one-cycle done pulse. It sits beside the combinational ALU units and serves the div/rem opcodes that cannot complete in a single cycle.

---
 rtl/alu_div32.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_div32.sv
// rtl/alu_div32.sv - iterative restoring 32-bit divider, one quotient bit per clock
module alu_div32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op1,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             zero,
    output logic             N,
    output logic             overflow,
    output logic             divzero,
    output logic             carryout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a0;       // captured dividend
    logic [WIDTH-1:0] a1;       // captured divisor
    logic             sgn;      // signed mode
    logic             div0;     // divisor was zero
    logic             neg_q;    // quotient needs negation
    logic             neg_r;    // remainder needs negation
    logic [WIDTH-1:0] dvd;      // dividend magnitude, shifts into quotient
    logic [WIDTH-1:0] dvs;      // divisor magnitude
    logic [WIDTH-1:0] rem;      // partial remainder, always < dvs
    logic [CW-1:0]    count;

    logic             accept;
    logic             in_signed;
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] dvd_step;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             ovf_fix;

    assign in_signed = (op1 == 4'b0001);
    assign accept    = (state == S_IDLE) && start && ((op1 == 4'b0000) || in_signed);
    assign carryout  = 1'b0;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a zero divisor skips the loop but still passes through
    // FIX so its result and done land one edge after the accept
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = (in1 == '0) ? S_FIX : S_CALC;
            S_CALC: if (count == '0) state_next = S_FIX;
            S_FIX:  state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // One shift-subtract step and the sign-corrected final results
    always_comb begin
        rem_sh   = {rem, dvd[WIDTH-1]};
        ge       = rem_sh >= {1'b0, dvs};
        rem_step = ge ? (rem_sh[WIDTH-1:0] - dvs) : rem_sh[WIDTH-1:0];
        dvd_step = {dvd[WIDTH-2:0], ge};
        if (div0) begin
            q_fix = ALL_ONES;
            r_fix = a0;
        end else begin
            q_fix = neg_q ? (~dvd + 1'b1) : dvd;
            r_fix = neg_r ? (~rem + 1'b1) : rem;
        end
        ovf_fix = sgn && !div0 && (a0 == MIN_NEG) && (a1 == ALL_ONES);
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a0        <= '0;
            a1        <= '0;
            sgn       <= 1'b0;
            div0      <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            zero      <= 1'b0;
            N         <= 1'b0;
            overflow  <= 1'b0;
            divzero   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a0    <= in0;
                        a1    <= in1;
                        sgn   <= in_signed;
                        div0  <= (in1 == '0);
                        neg_q <= in_signed && (in0[WIDTH-1] ^ in1[WIDTH-1]);
                        neg_r <= in_signed && in0[WIDTH-1];
                        dvd   <= (in_signed && in0[WIDTH-1]) ? (~in0 + 1'b1) : in0;
                        dvs   <= (in_signed && in1[WIDTH-1]) ? (~in1 + 1'b1) : in1;
                        rem   <= '0;
                        count <= CW'(WIDTH - 1);
                        busy  <= 1'b1;
                    end
                end
                S_CALC: begin
                    rem   <= rem_step;
                    dvd   <= dvd_step;
                    count <= count - 1'b1;
                end
                S_FIX: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                    zero      <= (q_fix == '0);
                    N         <= q_fix[WIDTH-1];
                    overflow  <= ovf_fix;
                    divzero   <= div0;
                    done      <= 1'b1;
                end
                S_DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
